// File: rtl/lsu_pkg.sv
// Load/store unit shared definitions: funct3 access-size codes,
// FSM state encoding and the funct3 legalisation helper.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WAIT,
        S_WR,
        S_RESP
    } lsu_state_t;

    // Anything not meaningful for the access kind collapses to W.
    function automatic logic [2:0] norm_f3(
        input logic       store,
        input logic [2:0] f3
    );
        logic [2:0] r;
        r = F3_W;
        if (store) begin
            if (f3 == F3_B || f3 == F3_H) r = f3;
        end else begin
            if (f3 == F3_B || f3 == F3_H || f3 == F3_BU || f3 == F3_HU)
                r = f3;
        end
        return r;
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Core-side request/response bundle of the load/store unit.
// master: execute stage; slave: load_store_unit.
interface lsu_if #(
    parameter int ANCHO  = 32,
    parameter int ADDR_W = 12
);
    logic              req_valid;
    logic              req_ready;
    logic              req_store;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [ANCHO-1:0]  req_wdata;
    logic              resp_valid;
    logic [ANCHO-1:0]  resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_store, req_funct3, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_store, req_funct3, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/lsu_align.sv
// Lane steering: extracts/extends load data and merges sub-word store data
// into the word read from RAM. Ports: funct3_i, lane_i, rword_i, wdata_i ->
// load_ext_o, merged_o. Purely combinational.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int ANCHO = 32
) (
    input  logic [2:0]       funct3_i,
    input  logic [1:0]       lane_i,
    input  logic [ANCHO-1:0] rword_i,
    input  logic [ANCHO-1:0] wdata_i,
    output logic [ANCHO-1:0] load_ext_o,
    output logic [ANCHO-1:0] merged_o
);
    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b = rword_i[7:0];
        unique case (lane_i)
            2'd0: b = rword_i[7:0];
            2'd1: b = rword_i[15:8];
            2'd2: b = rword_i[23:16];
            2'd3: b = rword_i[31:24];
        endcase
        h = lane_i[1] ? rword_i[31:16] : rword_i[15:0];

        load_ext_o = rword_i;
        merged_o   = wdata_i;
        case (funct3_i)
            F3_B:  load_ext_o = {{24{b[7]}}, b};
            F3_BU: load_ext_o = {24'd0, b};
            F3_H:  load_ext_o = {{16{h[15]}}, h};
            F3_HU: load_ext_o = {16'd0, h};
            default: load_ext_o = rword_i;
        endcase

        case (funct3_i)
            F3_B: begin
                merged_o = rword_i;
                unique case (lane_i)
                    2'd0: merged_o[7:0]   = wdata_i[7:0];
                    2'd1: merged_o[15:8]  = wdata_i[7:0];
                    2'd2: merged_o[23:16] = wdata_i[7:0];
                    2'd3: merged_o[31:24] = wdata_i[7:0];
                endcase
            end
            F3_H: merged_o = lane_i[1]
                           ? {wdata_i[15:0], rword_i[15:0]}
                           : {rword_i[31:16], wdata_i[15:0]};
            default: merged_o = wdata_i;
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one access in flight to a single-port word RAM, with
// read-modify-write for sub-word stores. Ports: CLK, RST_n, bus (lsu_if
// slave), ram_we/ram_re/ram_addr/ram_din out, ram_dout in.
// Optional: LSU_MISALIGN_CHECK_EN reports misaligned H/W instead of aligning.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ANCHO  = 32,
    parameter int LARGO  = 1024,
    parameter int ADDR_W = $clog2(LARGO) + 2
) (
    input  logic                     CLK,
    input  logic                     RST_n,
    lsu_if.slave                     bus,
    output logic                     ram_we,
    output logic                     ram_re,
    output logic [$clog2(LARGO)-1:0] ram_addr,
    output logic [ANCHO-1:0]         ram_din,
    input  logic [ANCHO-1:0]         ram_dout
);
    lsu_state_t        state_q, state_d;
    logic              store_q, store_d;
    logic [2:0]        f3_q, f3_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ANCHO-1:0]  wdata_q, wdata_d;
    logic [ANCHO-1:0]  rdata_q, rdata_d;
    logic [ANCHO-1:0]  din_q, din_d;
    logic              err_q, err_d;

    logic [2:0]        f3_n;
    logic [ADDR_W-1:0] addr_n;
    logic              mis;
    logic              is_h;
    logic              is_w;
    logic [ANCHO-1:0]  load_ext;
    logic [ANCHO-1:0]  merged;

    assign f3_n = norm_f3(bus.req_store, bus.req_funct3);
    assign is_h = (f3_n == F3_H) || (f3_n == F3_HU);
    assign is_w = (f3_n == F3_W);

`ifdef LSU_MISALIGN_CHECK_EN
    assign mis    = (is_h && bus.req_addr[0]) ||
                    (is_w && (bus.req_addr[1:0] != 2'b00));
    assign addr_n = bus.req_addr;
`else
    assign mis = 1'b0;
    always_comb begin
        addr_n = bus.req_addr;
        if (is_h) addr_n[0] = 1'b0;
        if (is_w) addr_n[1:0] = 2'b00;
    end
`endif

    lsu_align #(.ANCHO(ANCHO)) u_align (
        .funct3_i   (f3_q),
        .lane_i     (addr_q[1:0]),
        .rword_i    (ram_dout),
        .wdata_i    (wdata_q),
        .load_ext_o (load_ext),
        .merged_o   (merged)
    );

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q <= S_IDLE;
            store_q <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            din_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            store_q <= store_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            din_q   <= din_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        store_d = store_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        din_d   = din_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    store_d = bus.req_store;
                    f3_d    = f3_n;
                    addr_d  = addr_n;
                    wdata_d = bus.req_wdata;
                    rdata_d = '0;
                    err_d   = mis;
                    if (mis) begin
                        state_d = S_RESP;
                    end else if (bus.req_store && is_w) begin
                        din_d   = bus.req_wdata;
                        state_d = S_WR;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_RD:   state_d = S_WAIT;
            S_WAIT: begin
                if (store_q) begin
                    din_d   = merged;
                    state_d = S_WR;
                end else begin
                    rdata_d = load_ext;
                    state_d = S_RESP;
                end
            end
            S_WR:   state_d = S_RESP;
            S_RESP: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.req_ready  = (state_q == S_IDLE);
    assign bus.resp_valid = (state_q == S_RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
    assign ram_re         = (state_q == S_RD);
    assign ram_we         = (state_q == S_WR);
    assign ram_addr       = addr_q[ADDR_W-1:2];
    assign ram_din        = din_q;

endmodule
